// File: rtl/xyolo_write_ctrl.sv
// -----------------------------------------------------------------------------
// xyolo_write_ctrl
//
// Sequencer for the YOLO write stage of one conv tile. For every output pixel it
// walks a KxK window over the vread memory (one read per cycle, no bubbles),
// tags the first and last kernel element, and delays those tags to line up
// with the datapath:
//   ld_acc      = first tag, RD_LAT cycles after the read
//   ld_res      = last tag,  RD_LAT+1 cycles after the read
//   vwrite_enB  = RES_LAT cycles after ld_res
// Each result is written to vwrite memory at wr_base + result index.
// Address arithmetic uses only adders and wraps modulo the address width.
//
// Optional feature (macro XYOLO_WRITE_CTRL_MAXPOOL_EN):
//   With cfg_maxpool=1, ld_mp pulses with every ld_res and only every 4th result
//   (plus a trailing partial group) is written; the write address advances once
//   per group. Without the macro ld_mp is tied low and every result is written.
//
// Ports
//   clk, rst (async, active-high)
//   run                  start pulse, latches cfg_* (ignored while busy)
//   cfg_rd_base          vread address of the first window element
//   cfg_ker_w/ker_h      kernel size (0 treated as 1)
//   cfg_row_incr         address step between kernel rows
//   cfg_out_incr         window base step between outputs
//   cfg_n_out            number of outputs (0: short done-low pulse only)
//   cfg_wr_base          vwrite address of the first result
//   cfg_maxpool          group results by 4 (macro builds only)
//   vread_enB/addrB      vread memory read port
//   w_en/w_addr          weight fetch, w_addr = ky*ker_w + kx
//   ld_acc/ld_mp/ld_res  xyolo load strobes
//   vwrite_enB/addrB     vwrite memory write port
//   done                 1 when idle, 0 from run until the last write retired
// -----------------------------------------------------------------------------
module xyolo_write_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 10,
  parameter int CNT_W   = 10,
  parameter int RD_LAT  = 2,
  parameter int RES_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADDR_W-1:0]    cfg_rd_base,
  input  logic [CNT_W-1:0]     cfg_ker_w,
  input  logic [CNT_W-1:0]     cfg_ker_h,
  input  logic [ADDR_W-1:0]    cfg_row_incr,
  input  logic [ADDR_W-1:0]    cfg_out_incr,
  input  logic [CNT_W-1:0]     cfg_n_out,
  input  logic [WADDR_W-1:0]   cfg_wr_base,
  input  logic                 cfg_maxpool,
  output logic                 vread_enB,
  output logic [ADDR_W-1:0]    vread_addrB,
  output logic                 w_en,
  output logic [2*CNT_W-1:0]   w_addr,
  output logic                 ld_acc,
  output logic                 ld_mp,
  output logic                 ld_res,
  output logic                 vwrite_enB,
  output logic [WADDR_W-1:0]   vwrite_addrB,
  output logic                 done
);

  // Delay-line lengths: bit k of a line is visible k+1 cycles after the read.
  localparam int FL = RD_LAT;
  localparam int LL = RD_LAT + 1;
  localparam int WL = RD_LAT + RES_LAT + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t               r_state;
  logic                 r_done;

  // Latched configuration
  logic [CNT_W-1:0]     r_kw_m1, r_kh_m1, r_nout_m1;
  logic [ADDR_W-1:0]    r_row_incr, r_out_incr;

  // Counters describe the element currently presented on the read port
  logic [CNT_W-1:0]     r_kx, r_ky, r_out;
  logic [ADDR_W-1:0]    r_obase, r_rbase;

  // Read-port registers and tags of the element currently being read
  logic                 r_vread_en;
  logic [ADDR_W-1:0]    r_vread_addr;
  logic [2*CNT_W-1:0]   r_eidx;
  logic                 r_first, r_last, r_wtag;

  // Tag delay lines
  logic [FL-1:0]        r_first_sh;
  logic [LL-1:0]        r_last_sh;
  logic [WL-1:0]        r_wr_sh;

  // Write address: r_wnext is the address of the next write to retire
  logic [WADDR_W-1:0]   r_wnext, r_waddr;

  logic                 w_mp;

  // Next-element computation
  logic                 w_kx_end, w_ky_end, w_out_end, w_final;
  logic [CNT_W-1:0]     w_kx_nx, w_ky_nx, w_out_nx;
  logic [ADDR_W-1:0]    w_obase_nx, w_rbase_nx, w_addr_nx;
  logic [2*CNT_W-1:0]   w_eidx_nx;
  logic                 w_first_nx, w_last_nx, w_wtag_nx;

  // First-element values derived straight from cfg on the run cycle
  logic [CNT_W-1:0]     w_cfg_kw_m1, w_cfg_kh_m1, w_cfg_nout_m1;
  logic                 w_cfg_last0, w_cfg_wtag0;
  logic                 w_lines_empty;

`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
  logic                 r_mp;
  logic                 r_ld_mp;
  assign w_mp  = r_mp;
  assign ld_mp = r_ld_mp;
`else
  logic                 w_unused_maxpool;
  assign w_mp             = 1'b0;
  assign ld_mp            = 1'b0;
  assign w_unused_maxpool = cfg_maxpool;
`endif

  assign w_cfg_kw_m1   = (cfg_ker_w == '0) ? '0 : cfg_ker_w - CNT_W'(1);
  assign w_cfg_kh_m1   = (cfg_ker_h == '0) ? '0 : cfg_ker_h - CNT_W'(1);
  assign w_cfg_nout_m1 = cfg_n_out - CNT_W'(1);
  assign w_cfg_last0   = (w_cfg_kw_m1 == '0) && (w_cfg_kh_m1 == '0);
`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
  assign w_cfg_wtag0   = w_cfg_last0 && (!cfg_maxpool || (w_cfg_nout_m1 == '0));
`else
  assign w_cfg_wtag0   = w_cfg_last0;
`endif

  assign w_kx_end  = (r_kx  == r_kw_m1);
  assign w_ky_end  = (r_ky  == r_kh_m1);
  assign w_out_end = (r_out == r_nout_m1);
  assign w_final   = w_kx_end && w_ky_end && w_out_end;

  always_comb begin
    w_kx_nx    = r_kx;
    w_ky_nx    = r_ky;
    w_out_nx   = r_out;
    w_obase_nx = r_obase;
    w_rbase_nx = r_rbase;
    w_addr_nx  = r_vread_addr;
    w_eidx_nx  = r_eidx;
    w_first_nx = 1'b0;
    if (!w_kx_end) begin
      // next element in the same kernel row
      w_kx_nx   = r_kx + CNT_W'(1);
      w_addr_nx = r_vread_addr + ADDR_W'(1);
      w_eidx_nx = r_eidx + (2*CNT_W)'(1);
    end else if (!w_ky_end) begin
      // next kernel row of the same window
      w_kx_nx    = '0;
      w_ky_nx    = r_ky + CNT_W'(1);
      w_rbase_nx = r_rbase + r_row_incr;
      w_addr_nx  = r_rbase + r_row_incr;
      w_eidx_nx  = r_eidx + (2*CNT_W)'(1);
    end else begin
      // first element of the next output window
      w_kx_nx    = '0;
      w_ky_nx    = '0;
      w_out_nx   = r_out + CNT_W'(1);
      w_obase_nx = r_obase + r_out_incr;
      w_rbase_nx = r_obase + r_out_incr;
      w_addr_nx  = r_obase + r_out_incr;
      w_eidx_nx  = '0;
      w_first_nx = 1'b1;
    end
    w_last_nx = (w_kx_nx == r_kw_m1) && (w_ky_nx == r_kh_m1);
    // In maxpool mode only the 4th result of a group, or the very last result, is written
    w_wtag_nx = w_last_nx &&
                (!w_mp || (w_out_nx[1:0] == 2'b11) || (w_out_nx == r_nout_m1));
  end

  // Nothing in flight apart from a write retiring this cycle
  assign w_lines_empty = !r_vread_en && (r_first_sh == '0) && (r_last_sh == '0) &&
                         (r_wr_sh[WL-2:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b1;
      r_kw_m1      <= '0;
      r_kh_m1      <= '0;
      r_nout_m1    <= '0;
      r_row_incr   <= '0;
      r_out_incr   <= '0;
      r_kx         <= '0;
      r_ky         <= '0;
      r_out        <= '0;
      r_obase      <= '0;
      r_rbase      <= '0;
      r_vread_en   <= 1'b0;
      r_vread_addr <= '0;
      r_eidx       <= '0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_wtag       <= 1'b0;
      r_first_sh   <= '0;
      r_last_sh    <= '0;
      r_wr_sh      <= '0;
      r_wnext      <= '0;
      r_waddr      <= '0;
`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
      r_mp         <= 1'b0;
      r_ld_mp      <= 1'b0;
`endif
    end else begin
      // ---- issue stage: FSM and read port ----
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_kw_m1    <= w_cfg_kw_m1;
            r_kh_m1    <= w_cfg_kh_m1;
            r_nout_m1  <= w_cfg_nout_m1;
            r_row_incr <= cfg_row_incr;
            r_out_incr <= cfg_out_incr;
            r_wnext    <= cfg_wr_base;
            r_done     <= 1'b0;
`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
            r_mp       <= cfg_maxpool;
`endif
            if (cfg_n_out == '0) begin
              r_state <= S_DRAIN;
            end else begin
              // element 0 is presented in the first ISSUE cycle
              r_state      <= S_ISSUE;
              r_kx         <= '0;
              r_ky         <= '0;
              r_out        <= '0;
              r_obase      <= cfg_rd_base;
              r_rbase      <= cfg_rd_base;
              r_vread_en   <= 1'b1;
              r_vread_addr <= cfg_rd_base;
              r_eidx       <= '0;
              r_first      <= 1'b1;
              r_last       <= w_cfg_last0;
              r_wtag       <= w_cfg_wtag0;
            end
          end
        end
        S_ISSUE: begin
          if (w_final) begin
            r_state    <= S_DRAIN;
            r_vread_en <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_wtag     <= 1'b0;
          end else begin
            r_kx         <= w_kx_nx;
            r_ky         <= w_ky_nx;
            r_out        <= w_out_nx;
            r_obase      <= w_obase_nx;
            r_rbase      <= w_rbase_nx;
            r_vread_addr <= w_addr_nx;
            r_eidx       <= w_eidx_nx;
            r_first      <= w_first_nx;
            r_last       <= w_last_nx;
            r_wtag       <= w_wtag_nx;
          end
        end
        S_DRAIN: begin
          if (w_lines_empty) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // ---- tag delay lines ----
      r_first_sh <= FL'({r_first_sh, r_first});
      r_last_sh  <= LL'({r_last_sh, r_last});
      r_wr_sh    <= WL'({r_wr_sh, r_wtag});
`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
      r_ld_mp    <= r_last_sh[RD_LAT-1] & r_mp;
`endif

      // ---- write stage: address for the write retiring next cycle ----
      if (r_wr_sh[WL-2]) begin
        r_waddr <= r_wnext;
        r_wnext <= r_wnext + WADDR_W'(1);
      end
    end
  end

  assign vread_enB    = r_vread_en;
  assign vread_addrB  = r_vread_addr;
  assign w_en         = r_vread_en;
  assign w_addr       = r_eidx;
  assign ld_acc       = r_first_sh[FL-1];
  assign ld_res       = r_last_sh[LL-1];
  assign vwrite_enB   = r_wr_sh[WL-1];
  assign vwrite_addrB = r_waddr;
  assign done         = r_done;

endmodule

// File: tb/tb_xyolo_write_ctrl.sv
module tb_xyolo_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [9:0]  cfg_rd_base = '0;
  logic [9:0]  cfg_ker_w = '0;
  logic [9:0]  cfg_ker_h = '0;
  logic [9:0]  cfg_row_incr = '0;
  logic [9:0]  cfg_out_incr = '0;
  logic [9:0]  cfg_n_out = '0;
  logic [9:0]  cfg_wr_base = '0;
  logic        cfg_maxpool = 1'b0;
  logic        vread_enB;
  logic [9:0]  vread_addrB;
  logic        w_en;
  logic [19:0] w_addr;
  logic        ld_acc, ld_mp, ld_res;
  logic        vwrite_enB;
  logic [9:0]  vwrite_addrB;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  logic        t_en   [64];
  logic [9:0]  t_addr [64];
  logic [19:0] t_wa   [64];
  logic        t_acc  [64];
  logic        t_mp   [64];
  logic        t_res  [64];
  logic        t_vwe  [64];
  logic [9:0]  t_vwa  [64];
  logic        t_done [64];

  xyolo_write_ctrl dut (
    .clk(clk), .rst(rst), .run(run),
    .cfg_rd_base(cfg_rd_base), .cfg_ker_w(cfg_ker_w), .cfg_ker_h(cfg_ker_h),
    .cfg_row_incr(cfg_row_incr), .cfg_out_incr(cfg_out_incr), .cfg_n_out(cfg_n_out),
    .cfg_wr_base(cfg_wr_base), .cfg_maxpool(cfg_maxpool),
    .vread_enB(vread_enB), .vread_addrB(vread_addrB), .w_en(w_en), .w_addr(w_addr),
    .ld_acc(ld_acc), .ld_mp(ld_mp), .ld_res(ld_res),
    .vwrite_enB(vwrite_enB), .vwrite_addrB(vwrite_addrB), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, obs, exp_v);
    end
  endtask

  // Pulse run, then sample every cycle mid-cycle; sample c is cycle c of ISSUE.
  task automatic start_and_record(input int ncyc, input int mid_run);
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      t_en[c] = vread_enB;   t_addr[c] = vread_addrB; t_wa[c] = w_addr;
      t_acc[c] = ld_acc;     t_mp[c] = ld_mp;         t_res[c] = ld_res;
      t_vwe[c] = vwrite_enB; t_vwa[c] = vwrite_addrB; t_done[c] = done;
      run = (c == mid_run);
      if (c == mid_run) cfg_n_out = 10'd7;
      @(negedge clk);
    end
    run = 1'b0;
  endtask

  task automatic cfg_case1();
    cfg_rd_base = 10'd0; cfg_ker_w = 10'd3; cfg_ker_h = 10'd3; cfg_row_incr = 10'd8;
    cfg_out_incr = 10'd1; cfg_n_out = 10'd2; cfg_wr_base = 10'd100; cfg_maxpool = 1'b0;
  endtask

  task automatic cfg_case3();
    cfg_rd_base = 10'd5; cfg_ker_w = 10'd1; cfg_ker_h = 10'd1; cfg_row_incr = 10'd0;
    cfg_out_incr = 10'd1; cfg_n_out = 10'd5; cfg_wr_base = 10'd20; cfg_maxpool = 1'b0;
  endtask

  // 3x3 kernel, row step 8, 2 outputs: addr = out + ky*8 + kx at cycle out*9+ky*3+kx
  task automatic check_case1(input string pfx);
    for (int c = 0; c < 26; c++) begin
      chk({pfx, "_en"}, c, t_en[c], c <= 17);
      if (c <= 17) begin
        chk({pfx, "_addr"}, c, t_addr[c], (c / 9) + ((c % 9) / 3) * 8 + (c % 3));
        chk({pfx, "_waddr"}, c, t_wa[c], c % 9);
      end
      chk({pfx, "_ld_acc"}, c, t_acc[c], (c == 2) || (c == 11));
      chk({pfx, "_ld_res"}, c, t_res[c], (c == 11) || (c == 20));
      chk({pfx, "_vwe"}, c, t_vwe[c], (c == 13) || (c == 22));
      if (c == 13) chk({pfx, "_vwa"}, c, t_vwa[c], 100);
      if (c == 22) chk({pfx, "_vwa"}, c, t_vwa[c], 101);
      chk({pfx, "_done"}, c, t_done[c], c >= 23);
    end
  endtask

  // 1x1 kernel, 5 outputs from address 5
  task automatic check_case3(input string pfx);
    for (int c = 0; c < 13; c++) begin
      chk({pfx, "_en"}, c, t_en[c], c <= 4);
      if (c <= 4) begin
        chk({pfx, "_addr"}, c, t_addr[c], 5 + c);
        chk({pfx, "_waddr"}, c, t_wa[c], 0);
      end
      chk({pfx, "_ld_acc"}, c, t_acc[c], (c >= 2) && (c <= 6));
      chk({pfx, "_ld_res"}, c, t_res[c], (c >= 3) && (c <= 7));
      chk({pfx, "_vwe"}, c, t_vwe[c], (c >= 5) && (c <= 9));
      if ((c >= 5) && (c <= 9)) chk({pfx, "_vwa"}, c, t_vwa[c], 20 + c - 5);
      chk({pfx, "_done"}, c, t_done[c], c >= 10);
    end
  endtask

  initial begin
    int mp_cnt;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_done", 0, done, 1'b1);
    chk("rst_en", 0, vread_enB, 1'b0);
    chk("rst_addr", 0, vread_addrB, 0);
    chk("rst_acc", 0, ld_acc, 1'b0);
    chk("rst_res", 0, ld_res, 1'b0);
    chk("rst_mp", 0, ld_mp, 1'b0);
    chk("rst_vwe", 0, vwrite_enB, 1'b0);
    chk("rst_vwa", 0, vwrite_addrB, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 3x3 window, two outputs
    cfg_case1();
    start_and_record(26, -1);
    check_case1("c1");

    // 2: n_out = 0
    cfg_n_out = 10'd0;
    start_and_record(6, -1);
    for (int c = 0; c < 6; c++) begin
      chk("c2_en", c, t_en[c], 1'b0);
      chk("c2_vwe", c, t_vwe[c], 1'b0);
      chk("c2_done", c, t_done[c], c >= 1);
    end

    // 3: 1x1 kernel, back-to-back outputs
    cfg_case3();
    start_and_record(13, -1);
    check_case3("c3");

    // 4: maxpool grouping, 1x1 kernel, 8 outputs
    cfg_rd_base = 10'd0; cfg_ker_w = 10'd1; cfg_ker_h = 10'd1; cfg_out_incr = 10'd1;
    cfg_n_out = 10'd8; cfg_wr_base = 10'd40; cfg_maxpool = 1'b1;
    start_and_record(16, -1);
    mp_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (t_mp[c] === 1'b1) mp_cnt++;
`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
      chk("c4_ld_mp", c, t_mp[c], (c >= 3) && (c <= 10));
      chk("c4_vwe", c, t_vwe[c], (c == 8) || (c == 12));
      if (c == 8)  chk("c4_vwa", c, t_vwa[c], 40);
      if (c == 12) chk("c4_vwa", c, t_vwa[c], 41);
`else
      chk("c4_ld_mp", c, t_mp[c], 1'b0);
      chk("c4_vwe", c, t_vwe[c], (c >= 5) && (c <= 12));
      if ((c >= 5) && (c <= 12)) chk("c4_vwa", c, t_vwa[c], 40 + c - 5);
`endif
      chk("c4_done", c, t_done[c], c >= 13);
    end
`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
    chk("c4_mp_count", 0, mp_cnt, 8);
`else
    chk("c4_mp_count", 0, mp_cnt, 0);
`endif

    // 5a: run (with changed cfg) pulsed mid-ISSUE is ignored
    cfg_case1();
    start_and_record(26, 5);
    check_case1("c5a");

    // 5b: reset mid-ISSUE aborts, then a new run restarts cleanly
    cfg_case1();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (4) @(negedge clk);
    chk("c5b_pre_en", 4, vread_enB, 1'b1);
    rst = 1'b1;
    #1;
    chk("c5b_en", 0, vread_enB, 1'b0);
    chk("c5b_addr", 0, vread_addrB, 0);
    chk("c5b_acc", 0, ld_acc, 1'b0);
    chk("c5b_res", 0, ld_res, 1'b0);
    chk("c5b_vwe", 0, vwrite_enB, 1'b0);
    chk("c5b_done", 0, done, 1'b1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("c5b_idle_en", 0, vread_enB, 1'b0);
    chk("c5b_idle_done", 0, done, 1'b1);
    cfg_case3();
    start_and_record(13, -1);
    check_case3("c5b");

    // 6: read address wraps at the top of memory
    cfg_rd_base = 10'd1022; cfg_ker_w = 10'd4; cfg_ker_h = 10'd1; cfg_row_incr = 10'd0;
    cfg_out_incr = 10'd0; cfg_n_out = 10'd1; cfg_wr_base = 10'd5; cfg_maxpool = 1'b0;
    start_and_record(12, -1);
    for (int c = 0; c < 12; c++) begin
      chk("c6_en", c, t_en[c], c <= 3);
      chk("c6_ld_acc", c, t_acc[c], c == 2);
      chk("c6_ld_res", c, t_res[c], c == 6);
      chk("c6_vwe", c, t_vwe[c], c == 8);
      chk("c6_done", c, t_done[c], c >= 9);
    end
    chk("c6_addr", 0, t_addr[0], 1022);
    chk("c6_addr", 1, t_addr[1], 1023);
    chk("c6_addr", 2, t_addr[2], 0);
    chk("c6_addr", 3, t_addr[3], 1);
    chk("c6_vwa", 8, t_vwa[8], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
